// File: rtl/regfile_pkg.sv
// Shared constants and read-port slicing helpers for the regfile_sb register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  // Low bit of port `port` inside a flattened bus of `width`-bit fields.
  function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, issue sets and either write port clears,
// with a registered population count of the pending bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_waddr_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_waddr_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_waddr_i,
  output logic [DEPTH-1:0]  pending_o,
  output logic [ADDR_W:0]   pend_cnt_o
);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [DEPTH-1:0] set_v, clr_v;
  logic [ADDR_W:0]  cnt_q, cnt_d;

  // Register 0 can never become pending.
  assign set_v[ZERO_REG] = 1'b0;
  assign clr_v[ZERO_REG] = 1'b0;

  for (genvar a = 1; a < DEPTH; a++) begin : g_bit
    assign set_v[a] = iss_valid_i && (iss_waddr_i == ADDR_W'(a));
    assign clr_v[a] = (wb_we_i && (wb_waddr_i == ADDR_W'(a))) ||
                      (ld_we_i && (ld_waddr_i == ADDR_W'(a)));
  end

  // Set applied after clear: the newer instruction owns the register.
  always_comb begin
    pend_d = (pend_q & ~clr_v) | set_v;
    cnt_d  = (ADDR_W+1)'($countones(pend_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o  = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_waddr,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_waddr,
  input  logic [DATA_W-1:0]        wb_wdata,
  input  logic                     ld_we,
  input  logic [ADDR_W-1:0]        ld_waddr,
  input  logic [DATA_W-1:0]        ld_wdata,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wb_wr, ld_wr;

  assign wb_wr = wb_we && (wb_waddr != ZERO_A);
  assign ld_wr = ld_we && (ld_waddr != ZERO_A);

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .iss_valid_i (iss_valid),
    .iss_waddr_i (iss_waddr),
    .wb_we_i     (wb_wr),
    .wb_waddr_i  (wb_waddr),
    .ld_we_i     (ld_wr),
    .ld_waddr_i  (ld_waddr),
    .pending_o   (pending),
    .pend_cnt_o  (pend_cnt)
  );

  // Load return is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      if (wb_wr) mem_q[wb_waddr] <= wb_wdata;
      if (ld_wr) mem_q[ld_waddr] <= ld_wdata;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[port_lo(p, ADDR_W) +: ADDR_W];

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (!reset && rd_en[p] && (addr != ZERO_A)) begin
        data = mem_q[addr];
        busy = pending[addr];
`ifdef REGFILE_BYPASS_EN
        // A matching write resolves the hazard unless a new issue re-claims the register.
        if (ld_wr && (ld_waddr == addr)) begin
          data = ld_wdata;
          busy = iss_valid && (iss_waddr == addr);
        end else if (wb_wr && (wb_waddr == addr)) begin
          data = wb_wdata;
          busy = iss_valid && (iss_waddr == addr);
        end
`endif
      end
    end

    assign rd_data[port_lo(p, DATA_W) +: DATA_W] = data;
    assign rd_busy[p] = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_waddr;
  logic                     wb_we;
  logic [ADDR_W-1:0]        wb_waddr;
  logic [DATA_W-1:0]        wb_wdata;
  logic                     ld_we;
  logic [ADDR_W-1:0]        ld_waddr;
  logic [DATA_W-1:0]        ld_wdata;
  logic [ADDR_W:0]          pend_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_waddr (iss_waddr),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .ld_we     (ld_we),
    .ld_waddr  (ld_waddr),
    .ld_wdata  (ld_wdata),
    .pend_cnt  (pend_cnt)
  );

  logic [DATA_W-1:0] ref_mem  [DEPTH];
  bit                ref_pend [DEPTH];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count();
    int n = 0;
    for (int a = 0; a < DEPTH; a++) n += int'(ref_pend[a]);
    return n;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a]  = '0;
      ref_pend[a] = 1'b0;
    end
  endtask

  // Expected read-port outputs from the model state plus this cycle's inputs.
  task automatic check_now();
    for (int p = 0; p < NUM_RD; p++) begin
      int a;
      logic [DATA_W-1:0] ed;
      logic eb;
      a  = int'(rd_addr[p*ADDR_W +: ADDR_W]);
      ed = '0;
      eb = 1'b0;
      if (!reset && rd_en[p] && a != 0) begin
        ed = ref_mem[a];
        eb = ref_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (ld_we && int'(ld_waddr) == a) begin
          ed = ld_wdata;
          eb = iss_valid && int'(iss_waddr) == a;
        end else if (wb_we && int'(wb_waddr) == a) begin
          ed = wb_wdata;
          eb = iss_valid && int'(iss_waddr) == a;
        end
`endif
      end
      chk($sformatf("rd_data[%0d] a=%0d", p, a), rd_data[p*DATA_W +: DATA_W], ed);
      chk($sformatf("rd_busy[%0d] a=%0d", p, a), DATA_W'(rd_busy[p]), DATA_W'(eb));
    end
    chk("pend_cnt", DATA_W'(pend_cnt), DATA_W'(ref_count()));
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else begin
      if (wb_we && wb_waddr != 0) begin
        ref_mem[wb_waddr]  = wb_wdata;
        ref_pend[wb_waddr] = 1'b0;
      end
      if (ld_we && ld_waddr != 0) begin
        ref_mem[ld_waddr]  = ld_wdata;
        ref_pend[ld_waddr] = 1'b0;
      end
      if (iss_valid && iss_waddr != 0) ref_pend[iss_waddr] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    iss_valid = 1'b0; iss_waddr = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    ld_we = 1'b0; ld_waddr = '0; ld_wdata = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic read_all(input logic [ADDR_W-1:0] a);
    rd_en = '1;
    for (int p = 0; p < NUM_RD; p++) rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    model_clear();
    cycle();
    cycle();
    reset = 1'b0;

    // Preload r5, then reset mid-run
    wb_we = 1'b1; wb_waddr = 5; wb_wdata = 32'h1234;
    cycle();
    set_idle(); read_all(5); iss_valid = 1'b1; iss_waddr = 6;
    cycle();
    set_idle(); read_all(5); #1;
    chk("r5_preload", rd_data[0 +: DATA_W], 32'h1234);
    chk("pend_before_reset", DATA_W'(pend_cnt), 32'd1);
    do_reset();
    set_idle(); read_all(5); #1;
    chk("r5_after_reset", rd_data[0 +: DATA_W], 32'h0);
    chk("pend_after_reset", DATA_W'(pend_cnt), 32'd0);
    chk("busy_after_reset", DATA_W'(rd_busy), 32'd0);

    // Issue r7, load returns three cycles later
    set_idle(); iss_valid = 1'b1; iss_waddr = 7; read_all(7);
    cycle();
    set_idle(); read_all(7); #1;
    chk("r7_busy_after_iss", DATA_W'(rd_busy[1]), 32'd1);
    chk("r7_pend_cnt", DATA_W'(pend_cnt), 32'd1);
    cycle();
    cycle();
    ld_we = 1'b1; ld_waddr = 7; ld_wdata = 32'hDEAD;
    cycle();
    set_idle(); read_all(7); #1;
    chk("r7_data", rd_data[DATA_W +: DATA_W], 32'hDEAD);
    chk("r7_busy_clear", DATA_W'(rd_busy[1]), 32'd0);
    chk("r7_pend_zero", DATA_W'(pend_cnt), 32'd0);
    cycle();

    // Dual write to a pending r3: load data wins
    set_idle(); iss_valid = 1'b1; iss_waddr = 3;
    cycle();
    set_idle(); read_all(3);
    wb_we = 1'b1; wb_waddr = 3; wb_wdata = 32'h11;
    ld_we = 1'b1; ld_waddr = 3; ld_wdata = 32'h22;
    cycle();
    set_idle(); read_all(3); #1;
    chk("r3_dual_data", rd_data[2*DATA_W +: DATA_W], 32'h22);
    chk("r3_pend_zero", DATA_W'(pend_cnt), 32'd0);
    cycle();

    // Issue and write r9 in the same cycle: set wins
    set_idle(); iss_valid = 1'b1; iss_waddr = 9; wb_we = 1'b1; wb_waddr = 9; wb_wdata = 32'h55; read_all(9);
    cycle();
    set_idle(); read_all(9); #1;
    chk("r9_data", rd_data[0 +: DATA_W], 32'h55);
    chk("r9_busy", DATA_W'(rd_busy[0]), 32'd1);
    chk("r9_pend_cnt", DATA_W'(pend_cnt), 32'd1);
    cycle();

    // Register 0 ignores writes and issues
    set_idle(); read_all(0); wb_we = 1'b1; wb_waddr = 0; wb_wdata = 32'hFFFF_FFFF;
    ld_we = 1'b1; ld_waddr = 0; ld_wdata = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_waddr = 0;
    cycle();
    set_idle(); read_all(0); #1;
    chk("r0_data", rd_data[0 +: DATA_W], 32'h0);
    chk("r0_busy", DATA_W'(rd_busy), 32'd0);
    chk("r0_pend_cnt", DATA_W'(pend_cnt), 32'd1);
    cycle();

    // Bypass on r4 across all ports, then with reads disabled
    set_idle(); wb_we = 1'b1; wb_waddr = 4; wb_wdata = 32'h44;
    cycle();
    set_idle(); read_all(4); wb_we = 1'b1; wb_waddr = 4; wb_wdata = 32'hAA; #1;
    for (int p = 0; p < NUM_RD; p++) begin
`ifdef REGFILE_BYPASS_EN
      chk($sformatf("bypass_p%0d", p), rd_data[p*DATA_W +: DATA_W], 32'hAA);
`else
      chk($sformatf("bypass_p%0d", p), rd_data[p*DATA_W +: DATA_W], 32'h44);
`endif
    end
    cycle();
    set_idle(); rd_addr = {NUM_RD{5'd4}}; wb_we = 1'b1; wb_waddr = 4; wb_wdata = 32'hBB; #1;
    chk("rd_en0_data", DATA_W'(rd_data), 32'h0);
    cycle();

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      rd_en     = NUM_RD'($urandom);
      for (int p = 0; p < NUM_RD; p++) rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 9));
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_waddr = ADDR_W'($urandom_range(0, 9));
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_waddr  = ADDR_W'($urandom_range(0, 9));
      wb_wdata  = $urandom;
      ld_we     = ($urandom_range(0, 3) == 0);
      ld_waddr  = ADDR_W'($urandom_range(0, 9));
      ld_wdata  = $urandom;
      if (reset) model_clear();
      cycle();
    end
    reset = 1'b0;
    set_idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
